// File: rtl/miss_buf_pkg.sv
// miss_buf_pkg
//   Shared definitions for the L1_D miss buffer: default width constants,
//   the controller state enum and the queued request entry.
//   The entry address field is sized to the default address width; a
//   miss_buffer instance with a narrower ADDR_W zero-extends into it.
package miss_buf_pkg;

    localparam int MB_DEPTH  = 4;
    localparam int MB_ADDR_W = 64;
    localparam int MB_LINE_W = 128;
    localparam int MB_DATA_W = 64;
    localparam int MB_SIZE_W = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } mb_state_e;

    typedef struct packed {
        logic                 we;
        logic [MB_ADDR_W-1:0] addr;
        logic [MB_DATA_W-1:0] wdata;
        logic [MB_SIZE_W-1:0] size;
        logic                 clf;
    } mb_entry_t;

    // Only plain reads expect a fill back; writes and line flushes are posted.
    function automatic logic mb_is_read(input mb_entry_t e);
        return !e.we && !e.clf;
    endfunction

endpackage

// File: rtl/miss_buf_fifo.sv
// miss_buf_fifo
//   Circular FIFO of miss-buffer entries with registered pointers and count.
//   Ports:
//     clk, rst_n      clock and synchronous active-low reset
//     push, push_data write push_data at the tail (ignored when full)
//     pop             drop the head entry (ignored when empty)
//     head            current head entry (don't-care when empty)
//     full, empty     occupancy flags
//     count           number of stored entries, 0..DEPTH
module miss_buf_fifo
    import miss_buf_pkg::*;
#(
    parameter int DEPTH = MB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  mb_entry_t                push_data,
    input  logic                     pop,
    output mb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/miss_buffer.sv
// miss_buffer
//   Queues L1_D miss/forward requests and issues them to L2 in order, with at
//   most one read outstanding. Read fills are registered and returned to L1_D
//   as a one-cycle rsp_valid pulse; writes and cache-line flushes are posted.
//   Ports:
//     clk, rst_n                         clock, synchronous active-low reset
//     req_valid/req_ready                L1_D request handshake
//     req_we, req_addr, req_wdata,
//     req_size, req_clf                  request payload
//     rsp_valid, rsp_data                read fill back to L1_D
//     l2_valid/l2_ready                  L2 request handshake
//     l2_we, l2_addr, l2_wdata,
//     l2_size, l2_clf                    head-of-queue payload to L2
//     l2_rsp_valid, l2_rsp_data          L2 read response
//     stat_reads, stat_writes, stat_full optional event counters
//   Optional feature: define MISS_BUF_STATS_EN to add the stat_* counters.
module miss_buffer
    import miss_buf_pkg::*;
#(
    parameter int DEPTH  = MB_DEPTH,
    parameter int ADDR_W = MB_ADDR_W,
    parameter int LINE_W = MB_LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [2:0]        req_size,
    input  logic              req_clf,
    output logic              rsp_valid,
    output logic [LINE_W-1:0] rsp_data,
    output logic              l2_valid,
    input  logic              l2_ready,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [63:0]       l2_wdata,
    output logic [2:0]        l2_size,
    output logic              l2_clf,
`ifdef MISS_BUF_STATS_EN
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_full,
`endif
    input  logic              l2_rsp_valid,
    input  logic [LINE_W-1:0] l2_rsp_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    mb_state_e        state_q;
    mb_state_e        state_d;
    mb_entry_t        push_entry;
    mb_entry_t        head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             rsp_take;

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign l2_valid  = (state_q == ISSUE);
    assign pop       = l2_valid && l2_ready;
    assign rsp_take  = (state_q == WAIT_RSP) && l2_rsp_valid;

    always_comb begin
        push_entry       = '0;
        push_entry.we    = req_we;
        push_entry.addr  = MB_ADDR_W'(req_addr);
        push_entry.wdata = req_wdata;
        push_entry.size  = req_size;
        push_entry.clf   = req_clf;
    end

    assign l2_we    = head.we;
    assign l2_addr  = head.addr[ADDR_W-1:0];
    assign l2_wdata = head.wdata;
    assign l2_size  = head.size;
    assign l2_clf   = head.clf;

    miss_buf_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // After a non-read pop we stay in ISSUE if anything is left, counting a
    // push landing on the same edge; otherwise the queue is drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (l2_ready) begin
                    if (mb_is_read(head)) begin
                        state_d = WAIT_RSP;
                    end else if ((count != CNT_W'(1)) || push) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if (l2_rsp_valid) begin
                    state_d = empty ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset drops any outstanding read, so a late L2 response lands in IDLE
    // and is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            rsp_valid <= rsp_take;
            if (rsp_take) begin
                rsp_data <= l2_rsp_data;
            end
        end
    end

`ifdef MISS_BUF_STATS_EN
    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_full   <= '0;
        end else begin
            if (push && !req_we && !req_clf) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (push && (req_we || req_clf)) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (full) begin
                stat_full <= stat_full + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_miss_buffer.sv
// tb_miss_buffer
//   Directed self-checking bench for miss_buffer (DEPTH=4, default widths).
//   Define MISS_BUF_STATS_EN to also cover the stat_* counters.
module tb_miss_buffer;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [63:0]  req_addr;
    logic [63:0]  req_wdata;
    logic [2:0]   req_size;
    logic         req_clf;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         l2_valid;
    logic         l2_ready;
    logic         l2_we;
    logic [63:0]  l2_addr;
    logic [63:0]  l2_wdata;
    logic [2:0]   l2_size;
    logic         l2_clf;
    logic         l2_rsp_valid;
    logic [127:0] l2_rsp_data;
`ifdef MISS_BUF_STATS_EN
    logic [31:0]  stat_reads;
    logic [31:0]  stat_writes;
    logic [31:0]  stat_full;
`endif

    int checks = 0;
    int errors = 0;

    miss_buffer #(
        .DEPTH  (4),
        .ADDR_W (64),
        .LINE_W (128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_clf      (req_clf),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .l2_valid     (l2_valid),
        .l2_ready     (l2_ready),
        .l2_we        (l2_we),
        .l2_addr      (l2_addr),
        .l2_wdata     (l2_wdata),
        .l2_size      (l2_size),
        .l2_clf       (l2_clf),
`ifdef MISS_BUF_STATS_EN
        .stat_reads   (stat_reads),
        .stat_writes  (stat_writes),
        .stat_full    (stat_full),
`endif
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_data  (l2_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [2:0] size,
                                 input logic clf);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_clf   = clf;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        l2_ready     = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = '0;
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_l2_valid", l2_valid, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_data", rsp_data, 0);

        $display("[TB] two posted writes in order");
        l2_ready = 1'b1;
        applyStimulus(1'b1, 1'b1, 64'h4000, 64'd8, 3'd3, 1'b0);
        tick();
        checkOutput("lat_l2_valid_first_cycle", l2_valid, 0);
        applyStimulus(1'b1, 1'b1, 64'h1000, 64'd3, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        checkOutput("wr0_l2_valid", l2_valid, 1);
        checkOutput("wr0_l2_we", l2_we, 1);
        checkOutput("wr0_l2_addr", l2_addr, 128'h4000);
        checkOutput("wr0_l2_wdata", l2_wdata, 128'd8);
        checkOutput("wr0_l2_size", l2_size, 128'd3);
        tick();
        checkOutput("wr1_l2_valid", l2_valid, 1);
        checkOutput("wr1_l2_addr", l2_addr, 128'h1000);
        checkOutput("wr1_l2_wdata", l2_wdata, 128'd3);
        checkOutput("wr1_rsp_valid", rsp_valid, 0);
        tick();
        checkOutput("wr_done_l2_valid", l2_valid, 0);
        checkOutput("wr_done_rsp_valid", rsp_valid, 0);

        $display("[TB] read with delayed fill blocks the next read");
        applyStimulus(1'b1, 1'b0, 64'h4001, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h4000, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        checkOutput("rd0_l2_valid", l2_valid, 1);
        checkOutput("rd0_l2_we", l2_we, 0);
        checkOutput("rd0_l2_clf", l2_clf, 0);
        checkOutput("rd0_l2_addr", l2_addr, 128'h4001);
        tick();
        checkOutput("wait1_l2_valid", l2_valid, 0);
        tick();
        checkOutput("wait2_l2_valid", l2_valid, 0);
        tick();
        checkOutput("wait3_l2_valid", l2_valid, 0);
        checkOutput("wait3_rsp_valid", rsp_valid, 0);
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = 128'h08;
        tick();
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = 128'hDEAD;
        checkOutput("fill0_rsp_valid", rsp_valid, 1);
        checkOutput("fill0_rsp_data", rsp_data, 128'h08);
        checkOutput("rd1_l2_valid", l2_valid, 1);
        checkOutput("rd1_l2_addr", l2_addr, 128'h4000);
        tick();
        checkOutput("fill0_pulse_end", rsp_valid, 0);
        checkOutput("fill0_data_held", rsp_data, 128'h08);
        checkOutput("rd1_wait_l2_valid", l2_valid, 0);
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = 128'h55;
        tick();
        l2_rsp_valid = 1'b0;
        checkOutput("fill1_rsp_valid", rsp_valid, 1);
        checkOutput("fill1_rsp_data", rsp_data, 128'h55);
        tick();
        checkOutput("fill1_pulse_end", rsp_valid, 0);
        checkOutput("rd_done_l2_valid", l2_valid, 0);
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = 128'h77;
        tick();
        l2_rsp_valid = 1'b0;
        checkOutput("idle_rsp_ignored_valid", rsp_valid, 0);
        checkOutput("idle_rsp_ignored_data", rsp_data, 128'h55);

        $display("[TB] backpressure with a full queue");
        l2_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 64'h100 + 64'(i), 64'(i), 3'd3, 1'b0);
            tick();
        end
        checkOutput("full_req_ready", req_ready, 0);
        checkOutput("full_l2_valid", l2_valid, 1);
        checkOutput("full_l2_addr", l2_addr, 128'h100);
        applyStimulus(1'b1, 1'b1, 64'h104, 64'd4, 3'd3, 1'b0);
        tick();
        checkOutput("stall_req_ready", req_ready, 0);
        checkOutput("stall_l2_addr", l2_addr, 128'h100);
        l2_ready = 1'b1;
        tick();
        l2_ready = 1'b0;
        checkOutput("no_bypass_req_ready", req_ready, 1);
        checkOutput("after_pop_l2_addr", l2_addr, 128'h101);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        checkOutput("fifth_in_req_ready", req_ready, 0);
        l2_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checkOutput($sformatf("drain_valid_%0d", i), l2_valid, 1);
            checkOutput($sformatf("drain_addr_%0d", i), l2_addr, 128'h100 + 128'(i));
            tick();
        end
        checkOutput("drain_done_l2_valid", l2_valid, 0);

        $display("[TB] sustained push and pop with pointer wrap");
        l2_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 64'h200 + 64'(i), 64'(i), 3'd3, 1'b0);
            tick();
        end
        l2_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b1, 1'b1, 64'h204 + 64'((k == 0) ? 0 : k - 1), 64'(k), 3'd3, 1'b0);
            checkOutput($sformatf("stream_addr_%0d", k), l2_addr, 128'h200 + 128'(k));
            checkOutput($sformatf("stream_ready_%0d", k), req_ready, (k != 0) ? 1 : 0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        for (int k = 9; k < 12; k++) begin
            checkOutput($sformatf("stream_addr_%0d", k), l2_addr, 128'h200 + 128'(k));
            tick();
        end
        checkOutput("stream_done_l2_valid", l2_valid, 0);

        $display("[TB] reset while a read is outstanding");
        applyStimulus(1'b1, 1'b0, 64'd30000, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 64'h300, 64'h1, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        checkOutput("rst_rd_l2_addr", l2_addr, 128'd30000);
        tick();
        checkOutput("rst_rd_waiting", l2_valid, 0);
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = 128'hBEEF;
        checkOutput("midrst_req_ready", req_ready, 1);
        checkOutput("midrst_l2_valid", l2_valid, 0);
        checkOutput("midrst_rsp_data", rsp_data, 0);
        tick();
        l2_rsp_valid = 1'b0;
        checkOutput("late_rsp_valid", rsp_valid, 0);
        checkOutput("late_rsp_data", rsp_data, 0);
        checkOutput("late_l2_valid", l2_valid, 0);
        tick();
        checkOutput("discarded_l2_valid", l2_valid, 0);
        checkOutput("discarded_req_ready", req_ready, 1);

`ifdef MISS_BUF_STATS_EN
        $display("[TB] statistics counters");
        l2_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 64'h400, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 64'h401, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h402, 64'h0, 3'd3, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h403, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        tick();
        l2_ready = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 64'h404, 64'h0, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h405, 64'h0, 3'd3, 1'b0);
        checkOutput("stat_clf_head", l2_clf, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
        l2_ready = 1'b0;
        checkOutput("stat_writes", stat_writes, 3);
        checkOutput("stat_reads", stat_reads, 3);
        checkOutput("stat_full", stat_full, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/miss_buffer.md
MISS_BUFFER -- requirements
Module: miss_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 64, request address width.
REQ-003 SHALL have parameter LINE_W, default 128, fill/response line width.
REQ-004 SHALL have ports clk input 1 (sole clock) and rst_n input 1 (reset, synchronous, active-low).
REQ-005 SHALL have req_valid input 1 and req_ready output 1, the L1_D miss/forward handshake.
REQ-006 SHALL have req_we input 1 (1=write, 0=read) and req_addr input ADDR_W.
REQ-007 SHALL have req_wdata input 64, req_size input 3 (access size code) and req_clf input 1 (cache-line flush).
REQ-008 SHALL have rsp_valid output 1 and rsp_data output LINE_W, the read fill returned to L1_D.
REQ-009 SHALL have l2_valid output 1 and l2_ready input 1, the L2 request handshake.
REQ-010 SHALL have outputs l2_we 1, l2_addr ADDR_W, l2_wdata 64, l2_size 3 and l2_clf 1, all driven from the FIFO head entry.
REQ-011 SHALL have l2_rsp_valid input 1 and l2_rsp_data input LINE_W, the L2 read response.

Function
REQ-012 SHALL accept a request on a rising clk edge where req_valid and req_ready are both 1, storing {we, addr, wdata, size, clf} at the tail.
REQ-013 SHALL drive req_ready = (count != DEPTH), with no same-cycle bypass when full.
REQ-014 SHALL issue entries to L2 strictly in acceptance order; writes and CLF are posted and produce no rsp_valid.
REQ-015 SHALL run FSM states IDLE, ISSUE and WAIT_RSP, with l2_valid = (state == ISSUE).
REQ-016 IDLE -> ISSUE at the edge where count != 0.
REQ-017 ISSUE with l2_ready=1: pop head; head read -> WAIT_RSP; otherwise ISSUE if post-pop count != 0, else IDLE.
REQ-018 ISSUE with l2_ready=0: hold state and head outputs stable.
REQ-019 WAIT_RSP: SHALL ignore l2_ready and issue nothing further (one outstanding read maximum).
REQ-020 WAIT_RSP with l2_rsp_valid=1: register l2_rsp_data into rsp_data, pulse rsp_valid for exactly the next cycle, and go to ISSUE if count != 0, else IDLE.
REQ-021 SHALL ignore l2_rsp_valid outside WAIT_RSP.
REQ-022 SHALL hold rsp_data between pulses.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-024 Latency: a push into an empty FIFO in IDLE SHALL produce l2_valid in the second cycle after the accepting edge.
REQ-025 l2_* payload outputs SHALL be don't-care while l2_valid=0.

Reset
REQ-026 rst_n=0 at an edge SHALL set state=IDLE, count=0, pointers=0, rsp_valid=0, rsp_data=0; consequently req_ready=1 and l2_valid=0.
REQ-027 Reset mid-operation SHALL discard all queued entries and any outstanding read; a late l2_rsp_valid after reset SHALL be ignored.

Configuration
REQ-028 With MISS_BUF_STATS_EN defined: outputs stat_reads 32, stat_writes 32 and stat_full 32 SHALL exist.
REQ-029 stat_reads and stat_writes SHALL increment per accepted read or write/CLF; stat_full SHALL increment per cycle with count == DEPTH.
REQ-030 All stat counters SHALL wrap at 2^32 and clear on reset.
REQ-031 Without MISS_BUF_STATS_EN: the stat ports and counters SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-032 Package miss_buf_pkg SHALL hold the FSM state enum, the entry struct {we, addr, wdata, size, clf} and the default width constants.
REQ-033 FIFO storage and pointers SHALL be sub-module miss_buf_fifo (push/pop/full/empty/count); FSM and response register live in miss_buffer.

Verification
REQ-034 Write 0x4000 data 8, then write 0x1000 data 3, l2_ready=1: two l2 writes in order, 0x4000 then 0x1000, no rsp_valid.
REQ-035 Read 0x4001, then L2 answers 3 cycles later with 0x0..08: single rsp_valid pulse with rsp_data=0x08; the following queued read 0x4000 is not issued until after the response.
REQ-036 Hold l2_ready=0 and push 5 requests with DEPTH=4: req_ready=0 after the 4th; the 5th is accepted only after the first pop; no entry is lost or reordered.
REQ-037 Simultaneous push and pop at count=4 across 8 cycles: count stays 4, pointer wrap is exercised, and issue order matches push order.
REQ-038 Assert rst_n=0 during WAIT_RSP for read 30000, then drive l2_rsp_valid: no rsp_valid, req_ready=1 and l2_valid=0 after reset.
REQ-039 With MISS_BUF_STATS_EN: 2 writes, 1 CLF, 3 reads and 2 full cycles -> stat_writes=3, stat_reads=3, stat_full=2.
